// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative write-through data cache
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_q;
  logic        sram_read_q;
  logic        sram_write_q;
  logic [63:0] valid0_q;
  logic [63:0] valid1_q;
  logic [63:0] lru_q;
  logic [9:0]  tag0_q  [64];
  logic [9:0]  tag1_q  [64];
  logic [63:0] data0_q [64];
  logic [63:0] data1_q [64];

  logic [31:0] offs;
  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        wsel;
  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        victim;
  logic [63:0] hit_line;
  logic        unused_addr_bits;

  // Data region starts at byte 1024; the split is taken on the rebased offset.
  assign offs             = address - 32'd1024;
  assign idx              = offs[8:3];
  assign tag              = offs[18:9];
  assign wsel             = offs[2];
  assign unused_addr_bits = ^{offs[31:19], offs[1:0]};

  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign sram_read    = sram_read_q;
  assign sram_write   = sram_write_q;

  always_comb begin
    hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
    hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
    hit      = hit0 || hit1;
    hit_line = hit1 ? data1_q[idx] : data0_q[idx];
    victim   = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);
  end

  always_comb begin
    ready = 1'b0;
    rdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (!MEM_W_EN && !MEM_R_EN) begin
          ready = 1'b1;
        end else if (!MEM_W_EN && hit) begin
          ready = 1'b1;
          rdata = wsel ? hit_line[63:32] : hit_line[31:0];
        end
      end
      READ: begin
        if (sram_ready) begin
          ready = 1'b1;
          rdata = wsel ? sram_rdata[63:32] : sram_rdata[31:0];
        end
      end
      WRITE: begin
        if (sram_ready) ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Tag/data arrays carry no reset; only valid and LRU state is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MEM_W_EN) begin
            state_q      <= WRITE;
            sram_write_q <= 1'b1;
            if (hit0) begin
              valid0_q[idx] <= 1'b0;
              lru_q[idx]    <= 1'b0;
            end else if (hit1) begin
              valid1_q[idx] <= 1'b0;
              lru_q[idx]    <= 1'b1;
            end
          end else if (MEM_R_EN && !hit) begin
            state_q     <= READ;
            sram_read_q <= 1'b1;
          end else if (MEM_R_EN) begin
            lru_q[idx] <= ~hit1;
          end
        end
        READ: begin
          if (sram_ready) begin
            if (victim) begin
              valid1_q[idx] <= 1'b1;
              tag1_q[idx]   <= tag;
              data1_q[idx]  <= sram_rdata;
            end else begin
              valid0_q[idx] <= 1'b1;
              tag0_q[idx]   <= tag;
              data0_q[idx]  <= sram_rdata;
            end
            lru_q[idx]  <= ~victim;
            state_q     <= IDLE;
            sram_read_q <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_q      <= IDLE;
            sram_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized bench for cache_controller against a set/way reference model
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 6;
  int cnt   = 0;

  logic [31:0] sram_mem [int unsigned];
  logic [31:0] ref_mem  [int unsigned];

  bit m_valid [2][64];
  int m_tag   [2][64];
  bit m_lru   [64];

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  function automatic logic [31:0] fill_pattern(input int unsigned w);
    return (w * 32'h9E3779B1) + 32'h01234567;
  endfunction

  function automatic logic [31:0] sram_rd(input int unsigned w);
    return sram_mem.exists(w) ? sram_mem[w] : fill_pattern(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : fill_pattern(w);
  endfunction

  // SRAM controller: completes after lat cycles of a held enable.
  assign sram_ready = (sram_read || sram_write) && (cnt == lat);

  always @(posedge clk) begin
    if (rst || !(sram_read || sram_write)) cnt <= 0;
    else cnt <= cnt + 1;
    if (sram_write && sram_ready) sram_mem[sram_address >> 2] = sram_wdata;
    sram_rdata <= {sram_rd(((sram_address & ~32'h7) >> 2) + 1), sram_rd((sram_address & ~32'h7) >> 2)};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      m_valid[0][s] = 1'b0;
      m_valid[1][s] = 1'b0;
      m_lru[s]      = 1'b0;
    end
  endtask

  task automatic model_access(input bit is_w, input logic [31:0] addr, input logic [31:0] d, output bit hit);
    int off, s, tg, way, vic;
    off = int'(addr) - 1024;
    s   = (off >> 3) % 64;
    tg  = (off >> 9) % 1024;
    way = -1;
    for (int k = 0; k < 2; k++)
      if (m_valid[k][s] && m_tag[k][s] == tg) way = k;
    hit = (way >= 0);
    if (is_w) begin
      if (hit) begin
        m_valid[way][s] = 1'b0;
        m_lru[s]        = (way == 1);
      end
      ref_mem[addr >> 2] = d;
    end else if (hit) begin
      m_lru[s] = (way == 0);
    end else begin
      vic = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : int'(m_lru[s]));
      m_valid[vic][s] = 1'b1;
      m_tag[vic][s]   = tg;
      m_lru[s]        = (vic == 0);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the op.
  task automatic do_op(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] d,
                       output int waits, output logic [31:0] got);
    int rdc, wrc, exp_wait, exp_rdc, exp_wrc;
    bit hit, zbad, both;
    logic [31:0] exp_d;
    exp_d = ref_rd(addr >> 2);
    model_access(w, addr, d, hit);
    if (w) begin
      exp_wait = 1 + lat; exp_rdc = 0; exp_wrc = lat + 1;
    end else if (hit) begin
      exp_wait = 0; exp_rdc = 0; exp_wrc = 0;
    end else begin
      exp_wait = 1 + lat; exp_rdc = lat + 1; exp_wrc = 0;
    end
    address = addr; wdata = d; MEM_W_EN = w; MEM_R_EN = r;
    waits = 0; rdc = 0; wrc = 0; zbad = 0; both = 0;
    @(negedge clk);
    check("idle_sram_en", {30'd0, sram_read, sram_write}, 32'd0);
    check("sram_address", sram_address, addr);
    check("sram_wdata", sram_wdata, d);
    while (!ready && waits < 64) begin
      if (rdata != 32'd0) zbad = 1;
      if (sram_read && sram_write) both = 1;
      rdc += int'(sram_read);
      wrc += int'(sram_write);
      waits++;
      @(negedge clk);
    end
    rdc += int'(sram_read);
    wrc += int'(sram_write);
    check("wait_cycles", waits, exp_wait);
    check("sram_read_cycles", rdc, exp_rdc);
    check("sram_write_cycles", wrc, exp_wrc);
    check("rdata_zero_stalled", {31'd0, zbad}, 32'd0);
    check("rd_wr_exclusive", {31'd0, both}, 32'd0);
    got = rdata;
    if (r && !w) check("rdata", rdata, exp_d);
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int wt;
    logic [31:0] d;
    address = 32'd1024; wdata = 32'd0;
    sram_mem[1024 >> 2] = 32'h11111111; sram_mem[1028 >> 2] = 32'h22222222;
    ref_mem[1024 >> 2]  = 32'h11111111; ref_mem[1028 >> 2]  = 32'h22222222;

    apply_reset();
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_rdata", rdata, 32'd0);
    check("reset_sram_en", {30'd0, sram_read, sram_write}, 32'd0);
    @(posedge clk); #1;

    do_op(0, 1, 32'd1024, 32'd0, wt, d);
    check("first_miss_wait", wt, 32'd7);
    check("first_miss_data", d, 32'h11111111);
    do_op(0, 1, 32'd1028, 32'd0, wt, d);
    check("neighbour_hit_wait", wt, 32'd0);
    check("neighbour_hit_data", d, 32'h22222222);

    do_op(0, 1, 32'd1536, 32'd0, wt, d);
    do_op(0, 1, 32'd2048, 32'd0, wt, d);
    check("evict_fill_wait", wt, 32'd7);
    do_op(0, 1, 32'd1536, 32'd0, wt, d);
    check("survivor_hit_wait", wt, 32'd0);
    do_op(0, 1, 32'd1024, 32'd0, wt, d);
    check("evicted_miss_wait", wt, 32'd7);

    do_op(1, 0, 32'd1024, 32'hDEADBEEF, wt, d);
    do_op(0, 1, 32'd1024, 32'd0, wt, d);
    check("post_store_miss_wait", wt, 32'd7);
    check("post_store_data", d, 32'hDEADBEEF);

    do_op(1, 0, 32'd1064, 32'hCAFEF00D, wt, d);
    do_op(0, 1, 32'd1536, 32'd0, wt, d);
    check("unrelated_hit_wait", wt, 32'd0);

    do_op(1, 1, 32'd1536, 32'h0BADF00D, wt, d);

    address = 32'd1032; MEM_R_EN = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_read_active", {31'd0, sram_read}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("abort_sram_read", {31'd0, sram_read}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    do_op(0, 1, 32'd1024, 32'd0, wt, d);
    check("after_abort_miss_wait", wt, 32'd7);

    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [31:0] a;
      lat  = int'($urandom_range(1, 6));
      kind = int'($urandom_range(0, 9));
      a = 32'd1024 + ($urandom_range(0, 2) << 9) + ($urandom_range(0, 3) << 3)
          + ($urandom_range(0, 1) << 2) + $urandom_range(0, 3);
      if (kind < 6) do_op(0, 1, a, $urandom, wt, d);
      else if (kind < 9) do_op(1, 0, a, $urandom, wt, d);
      else do_op(1, 1, a, $urandom, wt, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
